// File: rtl/fifo_rd_packer_pkg.sv
// Shared types and defaults for the FIFO read-side packer.
package fifo_rd_packer_pkg;
  typedef enum logic {PK_FILL, PK_FULL} pack_state_e;
  localparam int PACK_RATIO_DEFAULT = 2;
  localparam int FIFO_WIDTH_DEFAULT = 16;
endpackage

// File: rtl/fifo_rd_packer_if.sv
// FIFO read port plus packed valid/ready output port of fifo_rd_packer.
interface fifo_rd_packer_if #(
  parameter int FIFO_WIDTH = 16,
  parameter int PACK_RATIO = 2
);
  logic                             fifo_empty;
  logic                             fifo_underflow;
  logic [FIFO_WIDTH-1:0]            fifo_data_out;
  logic                             fifo_rd_en;
  logic [FIFO_WIDTH*PACK_RATIO-1:0] out_data;
  logic [PACK_RATIO-1:0]            out_keep;
  logic                             out_valid;
  logic                             out_ready;
  logic                             rd_err;

  modport master (
    input  fifo_empty, fifo_underflow, fifo_data_out, out_ready,
    output fifo_rd_en, out_data, out_keep, out_valid, rd_err
  );
  modport slave (
    output fifo_empty, fifo_underflow, fifo_data_out, out_ready,
    input  fifo_rd_en, out_data, out_keep, out_valid, rd_err
  );
endinterface

// File: rtl/fifo_rd_timer.sv
// Saturating idle counter; expired is high once TIMEOUT_CYCLES idle cycles accumulate.
module fifo_rd_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] cnt;

  assign expired = (cnt == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt <= '0;
    else if (clr)           cnt <= '0;
    else if (inc && !expired) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/fifo_rd_packer.sv
// Drains a 1-cycle-latency FIFO and packs PACK_RATIO words into one output word.
// Optional partial-word flush on idle: define FIFO_RD_PACKER_TIMEOUT_EN.
module fifo_rd_packer
  import fifo_rd_packer_pkg::*;
#(
  parameter int FIFO_WIDTH     = FIFO_WIDTH_DEFAULT,
  parameter int PACK_RATIO     = PACK_RATIO_DEFAULT,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst,
  fifo_rd_packer_if.master bus
);
  localparam int CW = $clog2(PACK_RATIO + 1);

  pack_state_e                   state;
  logic [CW-1:0]                 fill_cnt;
  logic [CW-1:0]                 claimed;
  logic                          inflight;
  logic [FIFO_WIDTH-1:0]         assembly [PACK_RATIO];
  logic [FIFO_WIDTH*PACK_RATIO-1:0] asm_flat;
  logic [PACK_RATIO-1:0]         keep_nxt;
  logic                          capture, last_cap, transfer, idle, timeout;

  // Reads already in flight count against the lane budget so we never over-read.
  assign claimed        = fill_cnt + CW'(inflight);
  assign bus.fifo_rd_en = !bus.fifo_empty && (state == PK_FILL) &&
                          (claimed < CW'(PACK_RATIO));
  assign capture        = inflight;
  assign last_cap       = capture && (fill_cnt == CW'(PACK_RATIO - 1));
  assign transfer       = (state == PK_FULL) && (!bus.out_valid || bus.out_ready);
  assign idle           = (state == PK_FILL) && (fill_cnt != '0) && !inflight &&
                          bus.fifo_empty;

`ifdef FIFO_RD_PACKER_TIMEOUT_EN
  logic expired;

  fifo_rd_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (capture || transfer),
    .inc     (idle),
    .expired (expired)
  );

  // Flush only while idle so no read can be in flight when we leave FILL.
  assign timeout = idle && expired;

  for (genvar i = 0; i < PACK_RATIO; i++) begin : g_keep
    assign keep_nxt[i] = (CW'(i) < fill_cnt);
  end
`else
  assign timeout  = 1'b0;
  assign keep_nxt = '1;
`endif

  for (genvar i = 0; i < PACK_RATIO; i++) begin : g_lane
    assign asm_flat[i*FIFO_WIDTH +: FIFO_WIDTH] = assembly[i];

    always_ff @(posedge clk or posedge rst) begin
      if (rst)                                   assembly[i] <= '0;
      else if (transfer)                         assembly[i] <= '0;
      else if (capture && fill_cnt == CW'(i))    assembly[i] <= bus.fifo_data_out;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= PK_FILL;
      fill_cnt      <= '0;
      inflight      <= 1'b0;
      bus.out_data  <= '0;
      bus.out_keep  <= '0;
      bus.out_valid <= 1'b0;
      bus.rd_err    <= 1'b0;
    end else begin
      inflight <= bus.fifo_rd_en;
      if (bus.fifo_underflow) bus.rd_err <= 1'b1;

      if (capture) begin
        fill_cnt <= fill_cnt + 1'b1;
        if (last_cap) state <= PK_FULL;
      end else if (timeout) begin
        state <= PK_FULL;
      end

      if (transfer) begin
        bus.out_data  <= asm_flat;
        bus.out_keep  <= keep_nxt;
        bus.out_valid <= 1'b1;
        fill_cnt      <= '0;
        state         <= PK_FILL;
      end else if (bus.out_valid && bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fifo_rd_packer.sv
// Scoreboard bench for fifo_rd_packer with a behavioural 1-cycle-latency FIFO.
module tb_fifo_rd_packer;
  import fifo_rd_packer_pkg::*;

  localparam int W  = 16;
  localparam int PR = 2;
  localparam int T  = 16;

  typedef struct packed {
    logic [W*PR-1:0] data;
    logic [PR-1:0]   keep;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_rd_packer_if #(.FIFO_WIDTH(W), .PACK_RATIO(PR)) bus ();

  fifo_rd_packer #(.FIFO_WIDTH(W), .PACK_RATIO(PR), .TIMEOUT_CYCLES(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0, errors = 0;
  int mon_checks = 0, mon_errors = 0;
  int rd_cnt = 0, vld_cnt = 0;
  logic [W-1:0] fq[$];
  exp_t eq[$];

  // FIFO model: registered read data, empty flag refreshed every edge
  initial begin
    bus.fifo_empty    = 1'b1;
    bus.fifo_data_out = '0;
  end
  always @(posedge clk) begin
    if (bus.fifo_rd_en && !bus.fifo_empty && fq.size() > 0)
      bus.fifo_data_out <= fq.pop_front();
    bus.fifo_empty <= (fq.size() == 0);
  end

  // Output monitor: scoreboard pop on handshake, hold stability, no empty reads
  logic            hold_prev = 1'b0;
  logic [W*PR-1:0] prev_data;
  logic [PR-1:0]   prev_keep;
  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (bus.fifo_rd_en) begin
        rd_cnt++;
        mon_checks++;
        if (bus.fifo_empty) begin
          mon_errors++;
          $display("FAIL rd_en_while_empty: rd_en=%b empty=%b required empty=0", bus.fifo_rd_en, bus.fifo_empty);
        end
      end
      if (bus.out_valid) vld_cnt++;
      if (hold_prev) begin
        mon_checks++;
        if (!bus.out_valid || bus.out_data !== prev_data || bus.out_keep !== prev_keep) begin
          mon_errors++;
          $display("FAIL hold_stable: valid=%b data=%h keep=%b required valid=1 data=%h keep=%b",
                   bus.out_valid, bus.out_data, bus.out_keep, prev_data, prev_keep);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        mon_checks++;
        if (eq.size() == 0) begin
          mon_errors++;
          $display("FAIL unexpected_out: data=%h keep=%b required no output", bus.out_data, bus.out_keep);
        end else begin
          exp_t e;
          e = eq.pop_front();
          if (bus.out_data !== e.data || bus.out_keep !== e.keep) begin
            mon_errors++;
            $display("FAIL out_word: data=%h keep=%b required data=%h keep=%b",
                     bus.out_data, bus.out_keep, e.data, e.keep);
          end
        end
      end
      hold_prev = bus.out_valid && !bus.out_ready;
      prev_data = bus.out_data;
      prev_keep = bus.out_keep;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name, input int budget);
    for (int i = 0; i < budget && eq.size() != 0; i++) @(negedge clk);
    checks++;
    if (eq.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: pending=%0d required 0", name, eq.size());
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (bus.fifo_rd_en !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_data !== '0 ||
        bus.out_keep !== '0 || bus.rd_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: rd_en=%b valid=%b data=%h keep=%b err=%b required all 0",
               bus.fifo_rd_en, bus.out_valid, bus.out_data, bus.out_keep, bus.rd_err);
    end
    step(3);
    rst = 1'b0;
    step(1);
    fq.push_back(16'h1111);
    begin
      int n = 0;
      @(negedge clk);
      while (!bus.fifo_rd_en && n < 10) begin @(negedge clk); n++; end
      checks++;
      if (!bus.fifo_rd_en) begin
        errors++;
        $display("FAIL reset_first_rd: rd_en=%b required 1", bus.fifo_rd_en);
      end
    end
    step(1);
    rst = 1'b1;
    #1;
    checks++;
    if (bus.fifo_rd_en !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_keep !== '0) begin
      errors++;
      $display("FAIL reset_midword: rd_en=%b valid=%b data=%h keep=%b required all 0",
               bus.fifo_rd_en, bus.out_valid, bus.out_data, bus.out_keep);
    end
    step(2);
    rst = 1'b0;
    begin
      int v0 = vld_cnt;
      step(10);
      checks++;
      if (vld_cnt != v0) begin
        errors++;
        $display("FAIL reset_no_stale: valid_cycles=%0d required 0", vld_cnt - v0);
      end
    end
  endtask

  task automatic test_basic();
    int r0, v0;
    step(1);
    r0 = rd_cnt;
    v0 = vld_cnt;
    fq.push_back(16'hAAAA);
    fq.push_back(16'hBBBB);
    eq.push_back('{data: 32'hBBBB_AAAA, keep: 2'b11});
    drain("basic", 50);
    step(3);
    checks++;
    if (rd_cnt - r0 != 2) begin
      errors++;
      $display("FAIL basic_rd_cycles: got=%0d required 2", rd_cnt - r0);
    end
    checks++;
    if (vld_cnt - v0 != 1) begin
      errors++;
      $display("FAIL basic_valid_cycles: got=%0d required 1", vld_cnt - v0);
    end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) fq.push_back(W'(i));
    for (int i = 0; i < 4; i++)
      eq.push_back('{data: {W'(2*i+2), W'(2*i+1)}, keep: 2'b11});
    step(30);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h0002_0001 || bus.out_keep !== 2'b11) begin
      errors++;
      $display("FAIL bp_hold: valid=%b data=%h keep=%b required 1 00020001 11",
               bus.out_valid, bus.out_data, bus.out_keep);
    end
    checks++;
    if (fq.size() != 4) begin
      errors++;
      $display("FAIL bp_drained: remaining=%0d required 4", fq.size());
    end
    bus.out_ready = 1'b1;
    drain("bp", 100);
  endtask

  task automatic test_empty_mid();
    int v0;
    step(1);
    v0 = vld_cnt;
    fq.push_back(16'h1234);
    eq.push_back('{data: 32'h5678_1234, keep: 2'b11});
    step(8);
    checks++;
    if (vld_cnt != v0) begin
      errors++;
      $display("FAIL empty_mid_early: valid_cycles=%0d required 0", vld_cnt - v0);
    end
    fq.push_back(16'h5678);
    drain("empty_mid", 50);
    step(3);
    checks++;
    if (vld_cnt - v0 != 1) begin
      errors++;
      $display("FAIL empty_mid_count: valid_cycles=%0d required 1", vld_cnt - v0);
    end
  endtask

  task automatic test_underflow();
    step(1);
    checks++;
    if (bus.rd_err !== 1'b0) begin
      errors++;
      $display("FAIL uf_before: rd_err=%b required 0", bus.rd_err);
    end
    bus.fifo_underflow = 1'b1;
    step(1);
    bus.fifo_underflow = 1'b0;
    checks++;
    if (bus.rd_err !== 1'b1) begin
      errors++;
      $display("FAIL uf_set: rd_err=%b required 1", bus.rd_err);
    end
    step(10);
    checks++;
    if (bus.rd_err !== 1'b1) begin
      errors++;
      $display("FAIL uf_sticky: rd_err=%b required 1", bus.rd_err);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.rd_err !== 1'b0) begin
      errors++;
      $display("FAIL uf_clear: rd_err=%b required 0", bus.rd_err);
    end
    step(2);
    rst = 1'b0;
  endtask

  task automatic test_timeout();
    int v0;
    step(1);
    v0 = vld_cnt;
    fq.push_back(16'h00FF);
`ifdef FIFO_RD_PACKER_TIMEOUT_EN
    eq.push_back('{data: 32'h0000_00FF, keep: 2'b01});
    step(10);
    checks++;
    if (vld_cnt != v0) begin
      errors++;
      $display("FAIL timeout_early: valid_cycles=%0d required 0", vld_cnt - v0);
    end
    drain("timeout", 40);
`else
    step(100);
    checks++;
    if (vld_cnt != v0) begin
      errors++;
      $display("FAIL no_timeout: valid_cycles=%0d required 0", vld_cnt - v0);
    end
`endif
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  initial begin
    bus.fifo_underflow = 1'b0;
    bus.out_ready      = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_empty_mid();
    test_underflow();
    test_timeout();
    step(2);
    checks += mon_checks;
    errors += mon_errors;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
